// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM encoding,
// default halt encoding and a word-alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP           = 32'd4;

  // Control bundle from the fetch FSM to the IF/ID register.
  typedef struct packed {
    logic load;
    logic bubble;
  } if_id_ctrl_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: bubble beats load, load beats hold.
// A bubble clears every field so decode sees a clean no-op.
module if_id_register
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  if_id_ctrl_t ctrl,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (ctrl.bubble) begin
      instr_d    = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (ctrl.load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT/FAULT control FSM and
// delivered-instruction counter, feeding the IF/ID register.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 8192,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FetchCount
);

  // One bit wider than the PC so a memory that spans the full 4 GiB still compares correctly.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4;
  logic         pc_out_of_range;
  if_id_ctrl_t  if_id_ctrl;

  // Redirect targets are forced to word alignment, so the low bits are never read.
  logic unused_target_bits;
  assign unused_target_bits = ^BranchTarget[1:0];

  assign pc_plus4        = pc_q + PC_STEP;
  assign pc_out_of_range = {1'b0, pc_q} >= PC_LIMIT;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    count_d           = count_q;
    if_id_ctrl.load   = 1'b0;
    if_id_ctrl.bubble = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if_id_ctrl.bubble = 1'b1;
        state_d           = ST_RUN;
      end
      ST_RUN: begin
        if (BranchTaken) begin
          pc_d              = align_word(BranchTarget);
          if_id_ctrl.bubble = 1'b1;
        end else if (Flush) begin
          pc_d              = pc_plus4;
          if_id_ctrl.bubble = 1'b1;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (pc_out_of_range) begin
          // The PC is left pointing at the offending address for debug.
          if_id_ctrl.bubble = 1'b1;
          state_d           = ST_FAULT;
        end else if (Instruction == HALT_WORD) begin
          if_id_ctrl.bubble = 1'b1;
          state_d           = ST_HALT;
        end else begin
          pc_d            = pc_plus4;
          if_id_ctrl.load = 1'b1;
          count_d         = count_q + 32'd1;
        end
      end
      ST_HALT, ST_FAULT: begin
        if_id_ctrl.bubble = 1'b1;
      end
      default: begin
        if_id_ctrl.bubble = 1'b1;
        state_d           = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_BOOT;
      pc_q    <= align_word(RESET_PC);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_register u_if_id (
    .clk         (Clk),
    .rst         (Reset),
    .ctrl        (if_id_ctrl),
    .instr_in    (Instruction),
    .pc_plus4_in (pc_plus4),
    .instr_out   (Instruction_ID),
    .pc_plus4_out(PCPlus4_ID),
    .valid_out   (Valid_ID)
  );

  assign Address    = pc_q;
  assign Halted     = (state_q == ST_HALT);
  assign Fault      = (state_q == ST_FAULT);
  assign FetchCount = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural instruction memory
// plus a queue of expected deliveries popped whenever decode should see a new word.
module tb_instruction_fetch_unit;

  typedef enum {EXP_NEW, EXP_BUBBLE, EXP_HOLD} exp_kind_e;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } delivery_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Instruction_ID;
  logic [31:0] PCPlus4_ID;
  logic        Valid_ID;
  logic        Halted;
  logic        Fault;
  logic [31:0] FetchCount;

  logic [31:0] mem [0:8191];
  delivery_t   exp_q[$];
  logic [31:0] exp_count;
  int          tests_run = 0;
  int          tests_failed = 0;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(8192),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Address       (Address),
    .Instruction   (Instruction),
    .Stall         (Stall),
    .Flush         (Flush),
    .BranchTaken   (BranchTaken),
    .BranchTarget  (BranchTarget),
    .Instruction_ID(Instruction_ID),
    .PCPlus4_ID    (PCPlus4_ID),
    .Valid_ID      (Valid_ID),
    .Halted        (Halted),
    .Fault         (Fault),
    .FetchCount    (FetchCount)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    if (Address < 32'h0000_8000) Instruction = mem[Address[14:2]];
    else                         Instruction = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc_plus4);
    delivery_t d;
    d.instr    = instr;
    d.pc_plus4 = pc_plus4;
    exp_q.push_back(d);
  endtask

  // Advance one clock, then compare against the expected IF/ID behaviour.
  task automatic step(input exp_kind_e kind, input string tag);
    logic [31:0] prev_instr, prev_pcp4, prev_addr;
    logic        prev_valid;
    delivery_t   d;
    prev_instr = Instruction_ID;
    prev_pcp4  = PCPlus4_ID;
    prev_addr  = Address;
    prev_valid = Valid_ID;
    @(posedge Clk);
    #1;
    case (kind)
      EXP_NEW: begin
        exp_count = exp_count + 32'd1;
        check({tag, ".valid"}, {31'd0, Valid_ID}, 32'd1);
        check({tag, ".queued"}, 32'(exp_q.size()), (exp_q.size() == 0) ? 32'd1 : 32'(exp_q.size()));
        if (exp_q.size() != 0) begin
          d = exp_q.pop_front();
          check({tag, ".instr"}, Instruction_ID, d.instr);
          check({tag, ".pcp4"}, PCPlus4_ID, d.pc_plus4);
        end
      end
      EXP_BUBBLE: begin
        check({tag, ".valid"}, {31'd0, Valid_ID}, 32'd0);
        check({tag, ".instr"}, Instruction_ID, 32'd0);
      end
      default: begin
        check({tag, ".hold_valid"}, {31'd0, Valid_ID}, {31'd0, prev_valid});
        check({tag, ".hold_instr"}, Instruction_ID, prev_instr);
        check({tag, ".hold_pcp4"}, PCPlus4_ID, prev_pcp4);
        check({tag, ".hold_addr"}, Address, prev_addr);
      end
    endcase
    check({tag, ".count"}, FetchCount, exp_count);
  endtask

  task automatic apply_reset(input string tag);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    exp_q.delete();
    exp_count = 32'd0;
    check({tag, ".addr"}, Address, 32'd0);
    check({tag, ".instr"}, Instruction_ID, 32'd0);
    check({tag, ".pcp4"}, PCPlus4_ID, 32'd0);
    check({tag, ".valid"}, {31'd0, Valid_ID}, 32'd0);
    check({tag, ".halted"}, {31'd0, Halted}, 32'd0);
    check({tag, ".fault"}, {31'd0, Fault}, 32'd0);
    check({tag, ".count"}, FetchCount, 32'd0);
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    exp_count = 32'd0;
    @(posedge Clk);
    apply_reset("reset");

    // Straight-line fetch: first word lands two cycles after reset release.
    step(EXP_BUBBLE, "boot");
    check("boot.addr", Address, 32'd0);
    push(32'h11, 32'd4);  step(EXP_NEW, "seq0");
    push(32'h22, 32'd8);  step(EXP_NEW, "seq1");
    push(32'h33, 32'd12); step(EXP_NEW, "seq2");

    // Three-cycle stall freezes everything, then resumes without skip.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) step(EXP_HOLD, "stall");
    Stall = 1'b0;
    push(32'h44, 32'd16); step(EXP_NEW, "resume");
    check("resume.addr", Address, 32'd16);
    push(mem[4], 32'd20); step(EXP_NEW, "seq4");

    // Redirect wins over stall and aligns the target.
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h103;
    step(EXP_BUBBLE, "branch");
    check("branch.addr", Address, 32'h100);
    Stall = 1'b0; BranchTaken = 1'b0;
    push(mem[64], 32'h104); step(EXP_NEW, "target");

    // Flush discards the fetched word but still advances the PC.
    Flush = 1'b1;
    step(EXP_BUBBLE, "flush");
    check("flush.addr", Address, 32'h108);
    Flush = 1'b0;
    push(mem[66], 32'h10C); step(EXP_NEW, "postflush");

    // Last valid word, then fault at the first out-of-range address.
    BranchTaken = 1'b1; BranchTarget = 32'h7FFC;
    step(EXP_BUBBLE, "br_top");
    BranchTaken = 1'b0;
    check("br_top.addr", Address, 32'h7FFC);
    push(mem[8191], 32'h8000); step(EXP_NEW, "lastword");
    step(EXP_BUBBLE, "fault");
    check("fault.flag", {31'd0, Fault}, 32'd1);
    check("fault.addr", Address, 32'h8000);
    BranchTaken = 1'b1; BranchTarget = 32'h0;
    step(EXP_BUBBLE, "fault_sticky");
    check("fault_sticky.flag", {31'd0, Fault}, 32'd1);
    check("fault_sticky.addr", Address, 32'h8000);
    BranchTaken = 1'b0;

    // Halt encoding at 0x8: stops fetch, ignores redirects, only reset exits.
    mem[2] = 32'hFFFF_FFFF;
    apply_reset("reset2");
    step(EXP_BUBBLE, "boot2");
    push(32'h11, 32'd4); step(EXP_NEW, "h0");
    push(32'h22, 32'd8); step(EXP_NEW, "h1");
    step(EXP_BUBBLE, "halt");
    check("halt.flag", {31'd0, Halted}, 32'd1);
    check("halt.addr", Address, 32'h8);
    check("halt.count2", FetchCount, 32'd2);
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    step(EXP_BUBBLE, "halt_sticky");
    check("halt_sticky.flag", {31'd0, Halted}, 32'd1);
    check("halt_sticky.addr", Address, 32'h8);
    BranchTaken = 1'b0;
    mem[2] = 32'h33;

    // Reset mid-stall restores reset values, then BOOT, then RUN.
    apply_reset("reset3");
    step(EXP_BUBBLE, "boot3");
    push(32'h11, 32'd4); step(EXP_NEW, "r0");
    Stall = 1'b1;
    step(EXP_HOLD, "r_stall");
    apply_reset("reset_in_stall");
    step(EXP_BUBBLE, "boot4");
    check("boot4.addr", Address, 32'd0);
    Stall = 1'b0;
    push(32'h11, 32'd4); step(EXP_NEW, "r1");
    push(32'h22, 32'd8); step(EXP_NEW, "r2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
